// File: rtl/use_output_scheduler.sv
// use_output_scheduler: merges per-element records into one output stream in strict ring order
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   elem_ready/data/len per-element record-complete pulse, record bytes, byte length
//   in_tready          upstream may present the next beat (registered occupancy check)
//   m_tvalid/tready    output record handshake; m_tdata/m_tlen/m_tid carry the record
//   flush, flush_done  drain request and completion
//   overflow           sticky: a record arrived for an occupied slot
//   drop_count         saturating count of discarded records
module use_output_scheduler #(
  parameter int NUM_ELEMENTS = 4,
  parameter int MAX_USE_BYTES = 34,
  parameter int LEN_W = 6
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_ELEMENTS-1:0]                 elem_ready,
  input  logic [NUM_ELEMENTS*MAX_USE_BYTES*8-1:0] elem_data,
  input  logic [NUM_ELEMENTS*LEN_W-1:0]           elem_len,
  output logic                                    in_tready,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [MAX_USE_BYTES*8-1:0]              m_tdata,
  output logic [LEN_W-1:0]                        m_tlen,
  output logic [$clog2(NUM_ELEMENTS)-1:0]         m_tid,
  input  logic                                    flush,
  output logic                                    flush_done,
  output logic                                    overflow,
  output logic [15:0]                             drop_count
);
  localparam int ID_W = $clog2(NUM_ELEMENTS);
  localparam int DW = MAX_USE_BYTES*8;
  localparam logic [ID_W:0] OCC_MAX = (ID_W+1)'(NUM_ELEMENTS-2);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_ELEMENTS-1:0] slot_valid_q, slot_valid_d, drain, cap, lost, clash;
  logic [DW-1:0] slot_data_q [NUM_ELEMENTS];
  logic [LEN_W-1:0] slot_len_q [NUM_ELEMENTS];
  logic [ID_W-1:0] rd_ptr_q, rd_ptr_d, m_tid_q;
  logic [ID_W:0] occ_d;
  logic [16:0] drop_sum;
  logic [15:0] drop_count_q, drop_count_d;
  logic [DW-1:0] m_tdata_q;
  logic [LEN_W-1:0] m_tlen_q;
  logic load, skip, m_tvalid_q, in_tready_q, flush_done_q, overflow_q;
  assign in_tready = in_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata = m_tdata_q;
  assign m_tlen = m_tlen_q;
  assign m_tid = m_tid_q;
  assign flush_done = flush_done_q;
  assign overflow = overflow_q;
  assign drop_count = drop_count_q;
  always_comb begin
    load = slot_valid_q[rd_ptr_q] && (!m_tvalid_q || m_tready);
    // only FLUSH may step past an empty slot, and only if something is still waiting
    skip = (state_q == FLUSH) && !slot_valid_q[rd_ptr_q] && |slot_valid_q;
    drain = load ? (NUM_ELEMENTS)'(1) << rd_ptr_q : '0;
    slot_valid_d = '0;
    cap = '0;
    lost = '0;
    clash = '0;
    occ_d = '0;
    drop_sum = {1'b0, drop_count_q};
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      // a slot being drained this cycle is free to accept a new record
      cap[k] = elem_ready[k] && (elem_len[k*LEN_W +: LEN_W] != '0) && (!slot_valid_q[k] || drain[k]);
      clash[k] = elem_ready[k] && (elem_len[k*LEN_W +: LEN_W] != '0) && slot_valid_q[k] && !drain[k];
      lost[k] = (elem_ready[k] && (elem_len[k*LEN_W +: LEN_W] == '0)) || clash[k];
      slot_valid_d[k] = cap[k] || (slot_valid_q[k] && !drain[k]);
      occ_d = occ_d + (ID_W+1)'(slot_valid_d[k]);
      drop_sum = drop_sum + 17'(lost[k]);
    end
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    state_d = (state_q == RUN) ? (flush ? FLUSH : RUN)
            : (state_q == FLUSH) ? ((~|slot_valid_q && (!m_tvalid_q || m_tready)) ? DONE : FLUSH)
            : (flush ? DONE : RUN);
    rd_ptr_d = (state_q == DONE && !flush) ? '0
             : (load || skip) ? rd_ptr_q + ID_W'(1) : rd_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      slot_valid_q <= '0;
      rd_ptr_q <= '0;
      m_tvalid_q <= 1'b0;
      in_tready_q <= 1'b0;
      flush_done_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      slot_valid_q <= slot_valid_d;
      rd_ptr_q <= rd_ptr_d;
      m_tvalid_q <= load || (m_tvalid_q && !m_tready);
      in_tready_q <= (state_d != DONE) && (occ_d <= OCC_MAX);
      flush_done_q <= state_d == DONE;
      overflow_q <= overflow_q || |clash;
      drop_count_q <= drop_count_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      if (cap[k]) begin
        slot_data_q[k] <= elem_data[k*DW +: DW];
        slot_len_q[k] <= elem_len[k*LEN_W +: LEN_W];
      end
    end
    if (load) begin
      m_tdata_q <= slot_data_q[rd_ptr_q];
      m_tlen_q <= slot_len_q[rd_ptr_q];
      m_tid_q <= rd_ptr_q;
    end
  end
endmodule

// File: tb/tb_use_output_scheduler.sv
// tb_use_output_scheduler: directed scoreboard bench for use_output_scheduler
module tb_use_output_scheduler;
  localparam int N = 4;
  localparam int MB = 34;
  localparam int LW = 6;
  localparam int DW = MB*8;
  typedef struct packed {
    logic [1:0] tid;
    logic [LW-1:0] len;
    logic [DW-1:0] data;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_tready = 1'b1;
  logic flush = 1'b0;
  logic [N-1:0] elem_ready = '0;
  logic [N*DW-1:0] elem_data = '0;
  logic [N*LW-1:0] elem_len = '0;
  logic in_tready, m_tvalid, flush_done, overflow;
  logic [DW-1:0] m_tdata;
  logic [LW-1:0] m_tlen;
  logic [1:0] m_tid;
  logic [15:0] drop_count;
  rec_t exp_q[$];
  rec_t mon_e;
  logic [LW-1:0] drv_len [N];
  logic [DW-1:0] drv_data [N];
  logic [LW-1:0] a_len;
  logic [DW-1:0] a_data, held;
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int base;
  use_output_scheduler #(.NUM_ELEMENTS(N), .MAX_USE_BYTES(MB), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .elem_ready(elem_ready), .elem_data(elem_data),
    .elem_len(elem_len), .in_tready(in_tready), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlen(m_tlen), .m_tid(m_tid), .flush(flush),
    .flush_done(flush_done), .overflow(overflow), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [LW-1:0] len);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < MB; i++) if (i < int'(len)) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction
  task automatic push(input int k, input logic [LW-1:0] len, input logic [DW-1:0] data);
    rec_t r;
    r.tid = 2'(k);
    r.len = len;
    r.data = data;
    exp_q.push_back(r);
  endtask
  task automatic pulse(input logic [N-1:0] mask, input int len);
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        if (len != 0) for (int b = 0; b < MB; b++) elem_data[(k*MB+b)*8 +: 8] = 8'($urandom);
        elem_len[k*LW +: LW] = LW'(len);
        drv_len[k] = LW'(len);
        drv_data[k] = elem_data[k*DW +: DW];
      end
    end
    elem_ready = mask;
    tick();
    elem_ready = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    elem_ready = '0;
    flush = 1'b0;
    m_tready = 1'b1;
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
  endtask
  task automatic wait_out(input int n, input int bound);
    for (int i = 0; i < bound && out_cnt < n; i++) tick();
    chk("out_count", 64'(out_cnt), 64'(n));
  endtask
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !flush_done; i++) tick();
    chk("flush_done_set", 64'(flush_done), 64'd1);
  endtask
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL out_unexpected: got tid %0d expected no output", m_tid);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("out_tid", 64'(m_tid), 64'(mon_e.tid));
        chk("out_len", 64'(m_tlen), 64'(mon_e.len));
        checks++;
        assert (mask_bytes(m_tdata, m_tlen) === mask_bytes(mon_e.data, mon_e.len)) else begin
          errors++;
          $error("FAIL out_data: got %h expected %h", mask_bytes(m_tdata, m_tlen), mask_bytes(mon_e.data, mon_e.len));
        end
      end
      out_cnt++;
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    reset = 1'b0;
    chk("in_tready_before_edge", 64'(in_tready), 64'd0);
    tick();
    chk("in_tready_after_release", 64'(in_tready), 64'd1);
    pulse(4'b0001, 20);
    push(0, drv_len[0], drv_data[0]);
    chk("lat_t1_idle", 64'(m_tvalid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(m_tvalid), 64'd1);
    chk("lat_t2_tid", 64'(m_tid), 64'd0);
    chk("lat_t2_len", 64'(m_tlen), 64'd20);
    tick();
    chk("lat_one_cycle", 64'(m_tvalid), 64'd0);
    do_reset();
    pulse(4'b0100, 12);
    chk("order_wait_a", 64'(m_tvalid), 64'd0);
    pulse(4'b0010, 13);
    chk("order_wait_b", 64'(m_tvalid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("order_stall", 64'(m_tvalid), 64'd0);
    end
    pulse(4'b0001, 14);
    for (int k = 0; k < 3; k++) push(k, drv_len[k], drv_data[k]);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("order_valid", 64'(m_tvalid), 64'd1);
      chk("order_tid", 64'(m_tid), 64'(k));
    end
    tick();
    chk("order_end", 64'(m_tvalid), 64'd0);
    do_reset();
    m_tready = 1'b0;
    pulse(4'b0010, 10);
    a_len = drv_len[1];
    a_data = drv_data[1];
    chk("ovf_clear", 64'(overflow), 64'd0);
    chk("ovf_in_tready1", 64'(in_tready), 64'd1);
    pulse(4'b0010, 12);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_count), 64'd1);
    pulse(4'b0100, 8);
    chk("occ2_in_tready", 64'(in_tready), 64'd1);
    pulse(4'b1000, 9);
    chk("occ3_in_tready", 64'(in_tready), 64'd0);
    pulse(4'b0001, 11);
    tick();
    chk("hold_valid", 64'(m_tvalid), 64'd1);
    chk("hold_tid", 64'(m_tid), 64'd0);
    held = m_tdata;
    tick();
    tick();
    chk("hold_still_valid", 64'(m_tvalid), 64'd1);
    chk("hold_tid_stable", 64'(m_tid), 64'd0);
    chk("hold_len_stable", 64'(m_tlen), 64'd11);
    checks++;
    assert (m_tdata === held) else begin
      errors++;
      $error("FAIL hold_data: got %h expected %h", m_tdata, held);
    end
    base = out_cnt;
    m_tready = 1'b1;
    push(0, drv_len[0], drv_data[0]);
    push(1, a_len, a_data);
    push(2, drv_len[2], drv_data[2]);
    push(3, drv_len[3], drv_data[3]);
    wait_out(base + 4, 20);
    do_reset();
    base = out_cnt;
    pulse(4'b0010, 8);
    pulse(4'b1000, 9);
    push(1, drv_len[1], drv_data[1]);
    push(3, drv_len[3], drv_data[3]);
    tick();
    tick();
    chk("run_no_skip", 64'(m_tvalid), 64'd0);
    flush = 1'b1;
    wait_done(30);
    chk("flush_out_count", 64'(out_cnt), 64'(base + 2));
    chk("done_in_tready", 64'(in_tready), 64'd0);
    tick();
    chk("done_held", 64'(flush_done), 64'd1);
    flush = 1'b0;
    tick();
    chk("done_cleared", 64'(flush_done), 64'd0);
    chk("run_in_tready", 64'(in_tready), 64'd1);
    pulse(4'b0010, 7);
    push(1, drv_len[1], drv_data[1]);
    flush = 1'b1;
    wait_done(30);
    flush = 1'b0;
    tick();
    base = out_cnt;
    pulse(4'b0001, 5);
    push(0, drv_len[0], drv_data[0]);
    wait_out(base + 1, 10);
    do_reset();
    pulse(4'b0001, 0);
    tick();
    tick();
    chk("zero_len_no_out", 64'(m_tvalid), 64'd0);
    chk("zero_len_drop", 64'(drop_count), 64'd1);
    pulse(4'b1111, 0);
    chk("sum_drops", 64'(drop_count), 64'd5);
    for (int i = 0; i < 16000; i++) pulse(4'b1111, 0);
    chk("drop_count_mid", 64'(drop_count), 64'd64005);
    for (int i = 0; i < 1500; i++) pulse(4'b1111, 0);
    chk("drop_count_sat", 64'(drop_count), 64'hFFFF);
    do_reset();
    m_tready = 1'b0;
    pulse(4'b0001, 5);
    pulse(4'b0010, 5);
    pulse(4'b0100, 5);
    pulse(4'b1000, 5);
    pulse(4'b0010, 6);
    chk("pre_rst_valid", 64'(m_tvalid), 64'd1);
    chk("pre_rst_overflow", 64'(overflow), 64'd1);
    chk("pre_rst_in_tready", 64'(in_tready), 64'd0);
    reset = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
    chk("mid_rst_flush_done", 64'(flush_done), 64'd0);
    chk("mid_rst_in_tready", 64'(in_tready), 64'd0);
    reset = 1'b0;
    m_tready = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale_out", 64'(out_cnt), 64'(base));
    chk("no_stale_valid", 64'(m_tvalid), 64'd0);
    chk("post_rst_drop_count", 64'(drop_count), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/use_output_scheduler.md
USE_OUTPUT_SCHEDULER -- requirements
Module: use_output_scheduler

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 4: number of stream elements in the token ring, a power of 2 and at least 2.
REQ-002 SHALL have parameter MAX_USE_BYTES, default 34: maximum record width in bytes.
REQ-003 SHALL have parameter LEN_W, default 6: width of each length field, equal to clog2(MAX_USE_BYTES+1).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port elem_ready, input, NUM_ELEMENTS bits: per-element single-cycle record-complete pulse.
REQ-007 SHALL have port elem_data, input, NUM_ELEMENTS*MAX_USE_BYTES*8 bits: per-element record; element k occupies slice k.
REQ-008 SHALL have port elem_len, input, NUM_ELEMENTS*LEN_W bits: per-element record byte length.
REQ-009 SHALL have port in_tready, output, 1 bit: upstream may present the next bus beat.
REQ-010 SHALL have port m_tvalid, output, 1 bit: output record valid.
REQ-011 SHALL have port m_tready, input, 1 bit: downstream accepts the output record.
REQ-012 SHALL have port m_tdata, output, MAX_USE_BYTES*8 bits: record bytes, byte 0 in bits [7:0].
REQ-013 SHALL have port m_tlen, output, LEN_W bits: valid byte count of m_tdata.
REQ-014 SHALL have port m_tid, output, clog2(NUM_ELEMENTS) bits: source element index.
REQ-015 SHALL have port flush, input, 1 bit: level request to drain all pending records.
REQ-016 SHALL have port flush_done, output, 1 bit: flush complete.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag set when a record is lost.
REQ-018 SHALL have port drop_count, output, 16 bits: count of discarded records, saturating.

Function
REQ-019 SHALL hold one slot per element: slot_valid, slot_data and slot_len.
REQ-020 SHALL capture element k when elem_ready[k] is high and elem_len[k] is non-zero; slot_valid[k] is set on the next cycle.
REQ-021 SHALL discard a record whose elem_len is 0, without setting the slot, and SHALL increment drop_count.
REQ-022 SHALL, when elem_ready[k] arrives while slot k is valid and slot k is not being drained that cycle, keep the old record, set overflow and increment drop_count.
REQ-023 SHALL, when elem_ready[k] arrives in the same cycle slot k is drained, capture the new record with no overflow; the slot stays valid.
REQ-024 SHALL keep a read pointer rd_ptr, reset to 0, and emit records strictly in ring order 0,1,...,N-1,0.
REQ-025 SHALL use a single registered output stage, loaded from slot[rd_ptr] when that slot is valid and either m_tvalid is 0 or m_tready is 1.
REQ-026 SHALL, on each load, clear slot[rd_ptr] and advance rd_ptr modulo NUM_ELEMENTS, wrapping from N-1 to 0.
REQ-027 SHALL give a latency of 2 cycles from elem_ready[k] at cycle T to m_tvalid at T+2, when the output stage is empty and k equals rd_ptr.
REQ-028 SHALL hold m_tdata, m_tlen and m_tid stable while m_tvalid=1 and m_tready=0.
REQ-029 SHALL sustain one record per cycle under continuous m_tready=1.
REQ-030 SHALL drive in_tready = 1 only when the occupied-slot count is at most NUM_ELEMENTS-2, registered.
REQ-031 SHALL implement a state machine with states RUN, FLUSH and DONE.
REQ-032 SHALL go from RUN to FLUSH when flush=1.
REQ-033 SHALL, in FLUSH, skip rd_ptr past an empty slot when any other slot is valid, advancing one slot per cycle.
REQ-034 SHALL go from FLUSH to DONE when all slots are empty and the output stage is empty or is being accepted that cycle.
REQ-035 SHALL, in DONE, hold flush_done=1 and in_tready=0.
REQ-036 SHALL go from DONE to RUN when flush=0, setting rd_ptr to 0.
REQ-037 SHALL, in RUN, stall on an empty slot at rd_ptr and never skip it.
REQ-038 SHALL saturate drop_count at 0xFFFF and SHALL count at most one drop per element per cycle, summing simultaneous drops.

Reset
REQ-039 SHALL, on reset, clear all slot_valid bits, set rd_ptr=0, set state=RUN, and drive m_tvalid=0, flush_done=0, overflow=0, drop_count=0 and in_tready=0; in_tready rises one cycle after reset is released.
REQ-040 SHALL, on reset asserted mid-operation, discard all pending records without counting them as drops.
REQ-041 SHALL leave m_tdata, m_tlen and m_tid don't-care while m_tvalid=0.

Verification
REQ-042 SHALL be verified by: pulse elem_ready[0] with len=20 at T, with m_tready=1 -> m_tvalid at T+2 with m_tid=0, m_tlen=20 and 1-cycle duration.
REQ-043 SHALL be verified by: pulse elem_ready[2] then elem_ready[1] then elem_ready[0] -> output order 0,1,2, with no output before slot 0 fills.
REQ-044 SHALL be verified by: hold m_tready=0 and pulse elem_ready[1] twice -> overflow=1, drop_count=1, the first record retained, and in_tready dropping as occupancy reaches N-1.
REQ-045 SHALL be verified by: fill slots 1 and 3 only, then assert flush -> emits tid 1 then tid 3, then flush_done=1; deasserting flush gives RUN with rd_ptr=0.
REQ-046 SHALL be verified by: elem_len=0 pulse -> no output, drop_count increments; 70000 drops -> drop_count=0xFFFF.
REQ-047 SHALL be verified by: reset asserted with 3 slots valid and m_tvalid=1 -> next cycle all outputs at reset values, and no stale record emitted afterwards.
